// File: rtl/life_row_engine.sv
// -----------------------------------------------------------------------------
// life_row_engine
//   Game-of-Life generation engine for one row. Three adjacent rows (above,
//   centre, below) are loaded word by word. The engine then streams the
//   next-generation centre row out word by word and reports the row's
//   population count.
//
//   Handshakes: a transfer happens on a rising clk_i edge where valid and ready
//   are both high. The producer holds data stable while valid && !ready.
//   in_ready_o is high only in LOAD. out_valid_o is high only in EMIT, and
//   out_data_o/out_index_o do not change while out_valid_o && !out_ready_i.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       synchronous reset, active low
//   start_i      begin loading a row triple (honoured only in IDLE)
//   abort_i      return to IDLE next cycle from any state, row discarded
//   in_valid_i   input triple valid
//   in_ready_o   engine accepts triple
//   in_data_i    {below, centre, above} words of one word index
//   out_valid_o  next-generation word valid
//   out_ready_i  consumer accepts word
//   out_data_o   next-generation centre word
//   out_index_o  word index of out_data_o
//   done_o       one-cycle pulse after the last word is accepted
//   row_pop_o    live cells in emitted row, stable from done until next start
//   busy_o       engine not in IDLE
//   state_o      current FSM state (debug)
// -----------------------------------------------------------------------------
module life_row_engine #(
   parameter int         COLS    = 640,
   parameter int         WORD_W  = 16,
   parameter int         WRAP    = 1,
   parameter logic [8:0] BIRTH   = 9'b000001000,
   parameter logic [8:0] SURVIVE = 9'b000001100,
   localparam int        WORDS   = COLS / WORD_W,
   localparam int        IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1,
   localparam int        POP_W   = $clog2(COLS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [3*WORD_W-1:0]   in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [WORD_W-1:0]     out_data_o,
   output logic [IDX_W-1:0]      out_index_o,
   output logic                  done_o,
   output logic [POP_W-1:0]      row_pop_o,
   output logic                  busy_o,
   output logic [2:0]            state_o
);

   if (COLS % WORD_W != 0) begin : g_cols_check
      $error("life_row_engine: COLS must be a multiple of WORD_W");
   end

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_PREP = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Rule tables widened to 16 entries so a 4-bit neighbour count indexes them directly.
   localparam logic [15:0] BIRTH_T   = {7'b0, BIRTH};
   localparam logic [15:0] SURVIVE_T = {7'b0, SURVIVE};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [WORD_W-1:0]    out_data_q;
   logic [IDX_W-1:0]     out_index_q;
   logic                 done_q;
   logic [POP_W-1:0]     row_pop_q;
   logic                 busy_q;

   logic [WORD_W-1:0]    above_q  [WORDS];
   logic [WORD_W-1:0]    centre_q [WORDS];
   logic [WORD_W-1:0]    below_q  [WORDS];

   // -------------------------------------------------------------------------
   // Next-generation word for sel_idx. PREP computes word 0; EMIT computes the
   // word after the one currently presented.
   // -------------------------------------------------------------------------
   logic [IDX_W-1:0]     sel_idx, prv_idx, nxt_idx;
   logic                 edge_l, edge_r;
   logic [WORD_W+1:0]    ext_a, ext_c, ext_b;
   logic [WORD_W-1:0]    gen_word_d;
   logic [3:0]           n_cnt;
   logic [POP_W-1:0]     pop_word_d;

   always_comb begin
      sel_idx = '0;
      if (state_q == S_EMIT && idx_q != LAST_IDX) begin
         sel_idx = idx_q + IDX_W'(1);
      end
      prv_idx = (sel_idx == '0)      ? LAST_IDX : sel_idx - IDX_W'(1);
      nxt_idx = (sel_idx == LAST_IDX) ? '0      : sel_idx + IDX_W'(1);
      // Without wrap the columns just outside the row read as dead.
      edge_l  = (WRAP == 0) && (sel_idx == '0);
      edge_r  = (WRAP == 0) && (sel_idx == LAST_IDX);
      // ext_x[0] is column c-1 of bit 0, ext_x[WORD_W+1] is column c+1 of the top bit.
      ext_a = {(edge_r ? 1'b0 : above_q[nxt_idx][0]), above_q[sel_idx],
               (edge_l ? 1'b0 : above_q[prv_idx][WORD_W-1])};
      ext_c = {(edge_r ? 1'b0 : centre_q[nxt_idx][0]), centre_q[sel_idx],
               (edge_l ? 1'b0 : centre_q[prv_idx][WORD_W-1])};
      ext_b = {(edge_r ? 1'b0 : below_q[nxt_idx][0]), below_q[sel_idx],
               (edge_l ? 1'b0 : below_q[prv_idx][WORD_W-1])};
   end

   always_comb begin
      gen_word_d = '0;
      n_cnt      = '0;
      for (int k = 0; k < WORD_W; k++) begin
         n_cnt = 4'(ext_a[k]) + 4'(ext_a[k+1]) + 4'(ext_a[k+2])
               + 4'(ext_c[k])                  + 4'(ext_c[k+2])
               + 4'(ext_b[k]) + 4'(ext_b[k+1]) + 4'(ext_b[k+2]);
         gen_word_d[k] = ext_c[k+1] ? SURVIVE_T[n_cnt] : BIRTH_T[n_cnt];
      end
   end

   always_comb begin
      pop_word_d = '0;
      for (int k = 0; k < WORD_W; k++) begin
         pop_word_d = pop_word_d + POP_W'(out_data_q[k]);
      end
   end

   // -------------------------------------------------------------------------
   // Row storage
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int w = 0; w < WORDS; w++) begin
            above_q[w]  <= '0;
            centre_q[w] <= '0;
            below_q[w]  <= '0;
         end
      end else if (!abort_i && in_valid_i && in_ready_q) begin
         above_q[idx_q]  <= in_data_i[WORD_W-1:0];
         centre_q[idx_q] <= in_data_i[2*WORD_W-1:WORD_W];
         below_q[idx_q]  <= in_data_i[3*WORD_W-1:2*WORD_W];
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni || abort_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         done_q      <= 1'b0;
         row_pop_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q    <= S_LOAD;
                  idx_q      <= '0;
                  row_pop_q  <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (in_valid_i) begin
                  if (idx_q == LAST_IDX) begin
                     state_q    <= S_PREP;
                     idx_q      <= '0;
                     in_ready_q <= 1'b0;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            S_PREP: begin
               state_q     <= S_EMIT;
               out_data_q  <= gen_word_d;
               out_index_q <= '0;
               out_valid_q <= 1'b1;
            end
            S_EMIT: begin
               if (out_ready_i) begin
                  row_pop_q <= row_pop_q + pop_word_d;
                  if (idx_q == LAST_IDX) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     idx_q       <= sel_idx;
                     out_index_q <= sel_idx;
                     out_data_q  <= gen_word_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               idx_q   <= '0;
            end
            default: begin
               state_q     <= S_IDLE;
               idx_q       <= '0;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_index_o = out_index_q;
   assign done_o      = done_q;
   assign row_pop_o   = row_pop_q;
   assign busy_o      = busy_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_life_row_engine.sv
// -----------------------------------------------------------------------------
// tb_life_row_engine
//   Three engines share one stimulus stream:
//     inst 0: WRAP=1, B3/S23   inst 1: WRAP=0, B3/S23   inst 2: WRAP=1, B36/S23
//   All run in lockstep because timing does not depend on the rule or wrap.
// -----------------------------------------------------------------------------
module tb_life_row_engine;

   localparam int COLS   = 640;
   localparam int WORD_W = 16;
   localparam int WORDS  = 40;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_ni      = 1'b0;
   logic                start_i     = 1'b0;
   logic                abort_i     = 1'b0;
   logic                in_valid_i  = 1'b0;
   logic [3*WORD_W-1:0] in_data_i   = '0;
   logic                out_ready_i = 1'b0;

   logic                in_ready  [3];
   logic                out_valid [3];
   logic [WORD_W-1:0]   out_data  [3];
   logic [5:0]          out_index [3];
   logic                done      [3];
   logic [9:0]          row_pop   [3];
   logic                busy      [3];
   logic [2:0]          state     [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      life_row_engine #(
         .COLS    (COLS),
         .WORD_W  (WORD_W),
         .WRAP    ((g == 1) ? 0 : 1),
         .BIRTH   ((g == 2) ? 9'b001001000 : 9'b000001000),
         .SURVIVE (9'b000001100)
      ) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_ni),
         .start_i     (start_i),
         .abort_i     (abort_i),
         .in_valid_i  (in_valid_i),
         .in_ready_o  (in_ready[g]),
         .in_data_i   (in_data_i),
         .out_valid_o (out_valid[g]),
         .out_ready_i (out_ready_i),
         .out_data_o  (out_data[g]),
         .out_index_o (out_index[g]),
         .done_o      (done[g]),
         .row_pop_o   (row_pop[g]),
         .busy_o      (busy[g]),
         .state_o     (state[g])
      );
   end

   // ---------------- scoreboard ----------------
   int               checks = 0;
   int               errors = 0;
   logic [WORD_W-1:0] exp_q[$];   // per word: inst0, inst1, inst2
   logic [9:0]        pop_exp [3];
   logic [COLS-1:0]   row_a, row_c, row_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   // Loads the current row_a/row_c/row_b. abort_at >= 0 raises abort on that word.
   task automatic load_row(input int abort_at);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int g = 0; g < 3; g++) begin
         chk("load_state", state[g], 1);
         chk("load_busy", busy[g], 1);
         chk("load_pop_clear", row_pop[g], 0);
      end
      for (int w = 0; w < WORDS; w++) begin
         chk("in_ready", in_ready[0], 1);
         in_valid_i = 1'b1;
         in_data_i  = {row_b[w*WORD_W +: WORD_W], row_c[w*WORD_W +: WORD_W],
                       row_a[w*WORD_W +: WORD_W]};
         abort_i    = (w == abort_at);
         tick();
         if (w == abort_at) begin
            abort_i    = 1'b0;
            in_valid_i = 1'b0;
            for (int g = 0; g < 3; g++) begin
               chk("abort_state", state[g], 0);
               chk("abort_busy", busy[g], 0);
               chk("abort_in_ready", in_ready[g], 0);
               chk("abort_done", done[g], 0);
               chk("abort_pop", row_pop[g], 0);
            end
            return;
         end
      end
      in_valid_i = 1'b0;
      chk("prep_state", state[0], 2);
      chk("prep_out_valid", out_valid[0], 0);
      tick();
      for (int g = 0; g < 3; g++) begin
         chk("latency_valid", out_valid[g], 1);
         chk("first_index", out_index[g], 0);
      end
   endtask

   // Accepts n_words words; rnd randomises out_ready; start pulses at cycle start_at.
   task automatic emit(input int n_words, input bit rnd, input int start_at);
      int               got = 0;
      int               cyc = 0;
      bit               stalled = 1'b0;
      logic [WORD_W-1:0] hold_d [3];
      logic [5:0]        hold_i;
      logic [WORD_W-1:0] e;
      hold_i = '0;
      for (int g = 0; g < 3; g++) hold_d[g] = '0;
      while (got < n_words && cyc < 2000) begin
         out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start_i     = (cyc == start_at);
         for (int g = 0; g < 3; g++) chk("early_done", done[g], 0);
         if (stalled) begin
            for (int g = 0; g < 3; g++) begin
               chk("hold_data", out_data[g], hold_d[g]);
               chk("hold_index", out_index[g], hold_i);
            end
         end
         if (out_valid[0] && out_ready_i) begin
            for (int g = 0; g < 3; g++) begin
               e = exp_q.pop_front();
               chk($sformatf("word%0d_inst%0d", got, g), out_data[g], e);
               chk("index_order", out_index[g], got);
            end
            got++;
         end
         stalled = out_valid[0] && !out_ready_i;
         for (int g = 0; g < 3; g++) hold_d[g] = out_data[g];
         hold_i = out_index[0];
         tick();
         cyc++;
      end
      start_i     = 1'b0;
      out_ready_i = 1'b0;
      if (got < n_words) chk("emit_timeout", got, n_words);
   endtask

   task automatic finish_row();
      for (int g = 0; g < 3; g++) begin
         chk("done_pulse", done[g], 1);
         chk("done_out_valid", out_valid[g], 0);
         chk("done_row_pop", row_pop[g], pop_exp[g]);
      end
      tick();
      for (int g = 0; g < 3; g++) begin
         chk("done_once", done[g], 0);
         chk("idle_busy", busy[g], 0);
         chk("idle_state", state[g], 0);
         chk("pop_stable", row_pop[g], pop_exp[g]);
      end
   endtask

   // Centre row with a horizontal triplet in every word at bits p..p+2,
   // p = w%13+1; only the middle cell survives, so word w -> 1 << (w%13+2).
   task automatic set_triplet_rows();
      logic [WORD_W-1:0] one;
      one   = 16'd1;
      row_a = '0;
      row_b = '0;
      row_c = '0;
      for (int w = 0; w < WORDS; w++) begin
         for (int j = 0; j < 3; j++) row_c[w*WORD_W + (w % 13) + 1 + j] = 1'b1;
         for (int g = 0; g < 3; g++) exp_q.push_back(one << ((w % 13) + 2));
      end
      for (int g = 0; g < 3; g++) pop_exp[g] = 10'd40;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // Reset values
      repeat (3) tick();
      for (int g = 0; g < 3; g++) begin
         chk("rst_state", state[g], 0);
         chk("rst_in_ready", in_ready[g], 0);
         chk("rst_out_valid", out_valid[g], 0);
         chk("rst_done", done[g], 0);
         chk("rst_busy", busy[g], 0);
         chk("rst_out_data", out_data[g], 0);
         chk("rst_out_index", out_index[g], 0);
         chk("rst_row_pop", row_pop[g], 0);
      end
      rst_ni = 1'b1;
      tick();

      // start and abort together: abort wins
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      chk("start_abort_state", state[0], 0);
      chk("start_abort_busy", busy[0], 0);

      // Run A: blinker (cols 5..7), wrap corner, B36 six-neighbour cell.
      //   Wrap: above col 639, centre col 0, below col 0 live. Col 639 has
      //   3 neighbours only with wrap -> born; col 0 keeps 2 -> survives.
      //   B36: above/below cols 99..101 live, centre col 100 dead, n=6.
      row_a = '0; row_c = '0; row_b = '0;
      row_c[5] = 1'b1; row_c[6] = 1'b1; row_c[7] = 1'b1;
      row_a[639] = 1'b1; row_c[0] = 1'b1; row_b[0] = 1'b1;
      for (int k = 99; k <= 101; k++) begin
         row_a[k] = 1'b1;
         row_b[k] = 1'b1;
      end
      for (int w = 0; w < WORDS; w++) begin
         logic [WORD_W-1:0] e0, e1, e2;
         e0 = '0; e1 = '0; e2 = '0;
         if (w == 0)  begin e0 = 16'h0041; e1 = 16'h0040; e2 = 16'h0041; end
         if (w == 6)  e2 = 16'h0010;
         if (w == 39) begin e0 = 16'h8000; e2 = 16'h8000; end
         exp_q.push_back(e0);
         exp_q.push_back(e1);
         exp_q.push_back(e2);
      end
      pop_exp[0] = 10'd3; pop_exp[1] = 10'd1; pop_exp[2] = 10'd4;
      load_row(-1);
      emit(WORDS, 1'b0, -1);
      finish_row();

      // Run B: random backpressure over 40 distinct words
      set_triplet_rows();
      load_row(-1);
      emit(WORDS, 1'b1, -1);
      finish_row();

      // Abort during LOAD word 20
      load_row(20);
      tick();
      chk("post_abort_done", done[0], 0);

      // Reset low during EMIT after 10 words
      exp_q.delete();
      set_triplet_rows();
      load_row(-1);
      emit(10, 1'b0, -1);
      exp_q.delete();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      for (int g = 0; g < 3; g++) begin
         chk("rst_mid_state", state[g], 0);
         chk("rst_mid_busy", busy[g], 0);
         chk("rst_mid_out_valid", out_valid[g], 0);
         chk("rst_mid_done", done[g], 0);
         chk("rst_mid_pop", row_pop[g], 0);
         chk("rst_mid_out_data", out_data[g], 0);
      end
      tick();
      chk("rst_mid_no_done", done[0], 0);

      // Run D: all-ones rows -> every cell dies; start during EMIT ignored
      row_a = '1; row_c = '1; row_b = '1;
      for (int w = 0; w < WORDS; w++)
         for (int g = 0; g < 3; g++) exp_q.push_back(16'h0000);
      for (int g = 0; g < 3; g++) pop_exp[g] = 10'd0;
      load_row(-1);
      emit(WORDS, 1'b0, 5);
      finish_row();
      chk("exp_q_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #500000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
